// File: rtl/neuron.sv
// Two-stage signed multiply-accumulate neuron: y = ReLU(x1*w1 + x2*w2 + b).
// Define NEURON_SAT_EN to clamp positive overflow; otherwise the result wraps silently.
module neuron #(
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [DATA_W-1:0]   x1,
  input  logic signed [DATA_W-1:0]   x2,
  input  logic signed [DATA_W-1:0]   w1,
  input  logic signed [DATA_W-1:0]   w2,
  input  logic signed [DATA_W-1:0]   b,
  output logic signed [2*DATA_W-1:0] y
);

  localparam int PW = 2 * DATA_W;
  localparam int SW = PW + 2;

  // Largest value representable in the PW-bit signed output, widened to the sum width.
  localparam logic signed [SW-1:0] MAX_POS = {3'b000, {(PW-1){1'b1}}};

  logic signed [PW-1:0] p1;
  logic signed [PW-1:0] p2;
  logic signed [PW-1:0] bq;
  logic signed [SW-1:0] s;
  logic signed [PW-1:0] relu;

  // Stage 1: products and sign-extended bias. Reset wins over capture.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1 <= '0;
      p2 <= '0;
      bq <= '0;
    end else begin
      p1 <= x1 * w1;
      p2 <= x2 * w2;
      bq <= PW'(b);
    end
  end

  // Stage 2 combinational part: two guard bits make the three-term sum exact.
  // NOTE: relu gets a default before any branch so no latch is inferred.
  always_comb begin
    s    = SW'(p1) + SW'(p2) + SW'(bq);
    relu = '0;
    if (s > 0) begin
`ifdef NEURON_SAT_EN
      if (s > MAX_POS) relu = MAX_POS[PW-1:0];
      else             relu = s[PW-1:0];
`else
      relu = s[PW-1:0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) y <= '0;
    else     y <= relu;
  end

endmodule

// File: tb/tb_neuron.sv
// Directed self-checking bench for neuron (DATA_W=8): reset, ReLU, overflow,
// throughput and mid-operation reset, with hand-computed expected values.
module tb_neuron;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [7:0]  x1, x2, w1, w2, b;
  logic signed [15:0] y;

  int checks = 0;
  int errors = 0;

  neuron dut (
    .clk (clk),
    .rst (rst),
    .x1  (x1),
    .x2  (x2),
    .w1  (w1),
    .w2  (w2),
    .b   (b),
    .y   (y)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle #1 past it before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [15:0] exp);
    checks++;
    assert (y === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, y, exp);
    end
  endtask

  task automatic drive(input int a1, input int c1, input int a2, input int c2, input int bb);
    x1 = 8'(a1);
    w1 = 8'(c1);
    x2 = 8'(a2);
    w2 = 8'(c2);
    b  = 8'(bb);
  endtask

  initial begin
    // Reset for two cycles with all-zero inputs.
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    step();
    check("reset_cycle1", 16'sd0);
    step();
    check("reset_cycle2", 16'sd0);
    rst = 1'b0;
    step();
    check("post_release1", 16'sd0);
    step();
    check("post_release2", 16'sd0);

    // Positive case: 10*2 + 5*3 + 0 = 35, visible after exactly two edges.
    drive(10, 2, 5, 3, 0);
    step();
    check("latency_edge1", 16'sd0);
    step();
    check("positive_35", 16'sd35);
    step();
    check("stable_hold", 16'sd35);

    // ReLU negative: -50 + 4 + 10 = -36.
    drive(10, -5, 2, 2, 10);
    step();
    check("relu_edge1_old", 16'sd35);
    step();
    check("relu_negative", 16'sd0);

    // ReLU zero: -50 + 4 + 36 = 0.
    drive(10, -5, 2, 2, 36);
    step();
    step();
    check("relu_zero", 16'sd0);

    // Negative bias sign extension only: 0 + 0 - 1.
    drive(0, 0, 0, 0, -1);
    step();
    step();
    check("bias_neg_only", 16'sd0);

    // Negative*negative and mixed products: 12 + (-14) + 100 = 98.
    drive(-3, -4, 7, -2, 100);
    step();
    step();
    check("signed_products", 16'sd98);

    // Largest non-overflowing sum: 16384 + 16129 + 127 = 32640.
    drive(-128, -128, 127, 127, 127);
    step();
    step();
    check("near_max", 16'sd32640);

    // Overflow: 16384 + 16384 + 127 = 32895.
    drive(-128, -128, -128, -128, 127);
    step();
    step();
`ifdef NEURON_SAT_EN
    check("overflow_sat", 16'sd32767);
`else
    check("overflow_wrap", 16'sh807F);
`endif

    // Throughput: new vector every cycle -> 35, 0, 1 on consecutive cycles.
    drive(10, 2, 5, 3, 0);
    step();
    drive(10, -5, 2, 2, 10);
    step();
    check("tput_35", 16'sd35);
    drive(1, 1, 1, 1, -1);
    step();
    check("tput_0", 16'sd0);
    drive(0, 0, 0, 0, 0);
    step();
    check("tput_1", 16'sd1);
    step();
    check("tput_drain", 16'sd0);

    // Mid-operation reset: stage 1 holds 35 when reset hits; it must never emerge.
    drive(10, 2, 5, 3, 0);
    step();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    step();
    check("midrst_during", 16'sd0);
    rst = 1'b0;
    step();
    check("midrst_after1", 16'sd0);
    step();
    check("midrst_after2", 16'sd0);

    // Pipeline still works after the mid-operation reset.
    drive(10, 2, 5, 3, 0);
    step();
    step();
    check("recover_35", 16'sd35);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron.md
NEURON -- requirements
Module: neuron

Interface
REQ-001 Parameter: DATA_W, default 8, signed input operand width; output width fixed at 2*DATA_W.
REQ-002 The module SHALL use one clock; reset is synchronous and active-high.
REQ-003 The module SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 The module SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 The module SHALL have port x1  input  DATA_W signed  input activation 1.
REQ-006 The module SHALL have port x2  input  DATA_W signed  input activation 2.
REQ-007 The module SHALL have port w1  input  DATA_W signed  weight for x1.
REQ-008 The module SHALL have port w2  input  DATA_W signed  weight for x2.
REQ-009 The module SHALL have port b  input  DATA_W signed  bias, added unscaled and sign-extended.
REQ-010 The module SHALL have port y  output  2*DATA_W signed  registered ReLU output, never negative.

Function
REQ-011 The module SHALL compute y = ReLU(x1*w1 + x2*w2 + b) with full two's-complement signed arithmetic.
REQ-012 Stage 1 SHALL register p1 = x1*w1 and p2 = x2*w2, each 2*DATA_W signed, plus b sign-extended, on every rising clk edge.
REQ-013 Stage 2 SHALL form s = p1 + p2 + b in 2*DATA_W+2 signed bits, with no intermediate overflow.
REQ-014 Stage 2 SHALL apply ReLU and register the result into y.
REQ-015 ReLU: s < 0 SHALL give y = 0, and s = 0 SHALL give y = 0.
REQ-016 Latency SHALL be exactly 2 clk edges from input sample to y update.
REQ-017 The design SHALL be fully pipelined, accepting new inputs every cycle.
REQ-018 The design SHALL have no handshake; inputs are sampled unconditionally every cycle.
REQ-019 The design SHALL contain no combinational path from inputs to y.
REQ-020 Positive overflow (s > 2^(2*DATA_W-1)-1, reachable only with products near (-128)*(-128)) SHALL be handled per REQ-026/REQ-027.
REQ-021 Inputs held constant SHALL produce a stable y from the second edge onward.

Reset
REQ-022 While rst=1 at a rising edge, p1, p2, the bias register and y SHALL all load 0.
REQ-023 Reset SHALL take priority over data capture in the same cycle.
REQ-024 After rst deasserts, the first valid y SHALL appear 2 edges later; y stays 0 until then.
REQ-025 Reset asserted mid-operation SHALL discard in-flight pipeline data, with no stale value emerging afterward.

Configuration
REQ-026 With macro NEURON_SAT_EN defined, s above the maximum positive output SHALL clamp y to 2^(2*DATA_W-1)-1 (32767 at DATA_W=8).
REQ-027 Without NEURON_SAT_EN, y SHALL be s[2*DATA_W-1:0] when s >= 0, i.e. a silent wrap.
REQ-028 Without NEURON_SAT_EN, all other behaviour, including ReLU and latency, SHALL be identical to REQ-026 builds.

Verification
REQ-029 Reset: rst=1 for 2 cycles with x1=x2=w1=w2=b=0, then release -> y=0 throughout and for 2 cycles after release.
REQ-030 Positive: x1=10,w1=2,x2=5,w2=3,b=0 held -> y=35 two edges after sampling.
REQ-031 ReLU: x1=10,w1=-5,x2=2,w2=2,b=10 (s=-36) -> y=0 two edges later; b=36 (s=0) -> y=0.
REQ-032 Overflow: x1=x2=w1=w2=-128, b=127 (s=32895) -> y=32767 with NEURON_SAT_EN; y=32895 mod 65536 reinterpreted as 16 bits without it.
REQ-033 Throughput: change inputs every cycle (35, then -36, then b=-1 with x*w=1+1) -> y sequence 35, 0, 1 on consecutive cycles, each 2 edges delayed.
REQ-034 Mid-op reset: apply case REQ-030 and assert rst one edge later -> y stays 0, with no 35 emerging after reset.
